fpu_lat_pipe: RTL and testbench
===============================

# fpu_lat_pipe

Parametrised elastic result pipeline placed between the FPU datapath and the APU write-back port. It delays each FP result with its exception flags and destination tag by a configurable number of stages, and replaces the fixed per-format latency constants with a per-instance depth. It adds three things a bare register chain lacks:
- valid/ready back-pressure with bubble collapsing;
- an in-flight tag lookup for hazard checks;
- a sticky fflags accumulator for the CSR unit.

## Interface
Parameters:
- DATA_W, 32, result width; equals the FP register-file width (FLEN).
- FLAG_W, 5, exception-flag width (NV, DZ, OF, UF, NX).
- TAG_W, 5, destination-register tag width.
- LAT, 1, number of pipeline stages, legal range 0..8; 0 gives a combinational pass-through.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  kill all in-flight entries.
- in_valid_i  in  1  upstream result valid.
- in_ready_o  out  1  pipeline can accept.
- in_data_i  in  DATA_W  result.
- in_flags_i  in  FLAG_W  exception flags.
- in_tag_i  in  TAG_W  destination tag.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  write-back accepts.
- out_data_o  out  DATA_W  result.
- out_flags_o  out  FLAG_W  flags.
- out_tag_o  out  TAG_W  tag.
- chk_tag_i  in  TAG_W  tag to look up.
- chk_hit_o  out  1  chk_tag_i matches a valid in-flight entry.
- busy_o  out  1  any stage valid.
- fflags_o  out  FLAG_W  sticky accumulated flags.
- fflags_clr_i  in  1  clear sticky flags.

## Operation
- Structure: stages 0..LAT-1, each holding {valid, data, flags, tag}. Stage 0 is fed from the input; stage LAT-1 drives the out_* ports.
- Per-stage advance: stage k loads from stage k-1 (or from the input when k=0) when stage k is empty or is itself advancing this cycle.
  - Last stage advances on out_valid_o && out_ready_i.
  - in_ready_o = !valid[0] || advance[0]. It depends combinationally on out_ready_i through the chain.
- Data, flags and tag registers load only when their stage loads; otherwise they hold.
- LAT=0: out_valid_o = in_valid_i, in_ready_o = out_ready_i, out_* = in_*. chk_hit_o = 0, busy_o = 0.
- chk_hit_o = OR over k of (valid[k] && tag[k] == chk_tag_i). Purely combinational; the input port is not included.
- busy_o = OR of all valid[k].
- Sticky flags: on an output handshake, fflags_o <= fflags_o | out_flags_o.
  - fflags_clr_i alone: fflags_o <= 0.
  - Clear and handshake in the same cycle: fflags_o <= out_flags_o (clear first, then accumulate).
- Flush: all valid[k] cleared at the next edge.
  - An input handshake in the flush cycle is discarded.
  - An output handshake in the flush cycle still completes and still accumulates flags.
  - fflags_o is unaffected by the flush itself.
  - Data registers are not cleared.
- Reset (rst_ni low, asynchronous): all valid[k]=0, all data/flags/tag registers=0, fflags_o=0.
  - Resulting outputs: out_valid_o=0, out_data_o=0, out_flags_o=0, out_tag_o=0, chk_hit_o=0, busy_o=0, in_ready_o=1 (LAT>0).
  - Reset asserted mid-stream drops all entries with no output handshake.

## Timing
- Latency: an entry accepted at edge n is presented on out_* after edge n+LAT-1, i.e. visible in the cycle following the (LAT)th accepting edge, assuming no stall.
- Throughput: 1 result/cycle with out_ready_i held high.
- Stall: with out_ready_i=0 the pipeline fills completely, holding LAT entries. in_ready_o drops only when every stage is valid.
- Bubbles: an empty stage is filled even while downstream stalls (elastic, no fixed slot timing).
- Ordering: results exit strictly in acceptance order; there is no reordering or drop except by flush or reset.
- Output stability: out_* are stable while out_valid_o && !out_ready_i.
- Simultaneous events:
  - Full pipe plus output handshake plus input valid: input is accepted in the same cycle (in_ready_o=1).
  - flush_i has priority over in_valid_i.

## Test plan
- LAT=3, stream tags 1,2,3,4 with flags 0x01,0x00,0x04,0x10, out_ready_i=1 -> each output appears 3 cycles after its input, in order; fflags_o ends at 0x15.
- LAT=3, out_ready_i=0, push 4 entries -> 3 accepted, in_ready_o=0 on the 4th. Raise out_ready_i for one cycle -> tag 1 retires and the 4th entry is accepted in that same cycle.
- LAT=2, entry tag=7 in flight, chk_tag_i=7 -> chk_hit_o=1. After retirement -> 0. With chk_tag_i=6 -> 0 throughout.
- LAT=4, 3 entries in flight, flush_i together with a new input -> busy_o=0 and out_valid_o=0 next cycle; no retirements; fflags_o unchanged.
- fflags_o=0x03, fflags_clr_i together with a handshake whose flags are 0x08 -> fflags_o=0x08. Clear alone -> 0x00.
- LAT=0, in_valid_i=1, data 0x3F800000, out_ready_i toggling -> out_* mirror the input combinationally and in_ready_o mirrors out_ready_i. Separately, at any LAT, asserting rst_ni low mid-stream -> every output takes its reset value immediately.

Source files
------------

// File: rtl/fpu_lat_pipe.sv
// Elastic FP result pipeline: LAT valid/ready stages carrying {data, flags, tag},
// with in-flight tag lookup and a sticky fflags accumulator.

module fpu_lat_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         ld,
  input  logic         vld_in,
  input  logic [W-1:0] pay_in,
  output logic         vld,
  output logic [W-1:0] pay
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      pay <= '0;
    end else begin
      if (flush)   vld <= 1'b0;
      else if (ld) vld <= vld_in;
      // payload only captured when a real entry lands; bubbles leave it untouched
      if (ld && vld_in) pay <= pay_in;
    end
  end

endmodule

module fpu_lat_pipe #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 5,
  parameter int TAG_W  = 5,
  parameter int LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [FLAG_W-1:0] in_flags_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [FLAG_W-1:0] out_flags_o,
  output logic [TAG_W-1:0]  out_tag_o,
  input  logic [TAG_W-1:0]  chk_tag_i,
  output logic              chk_hit_o,
  output logic              busy_o,
  output logic [FLAG_W-1:0] fflags_o,
  input  logic              fflags_clr_i
);

  localparam int PW = DATA_W + FLAG_W + TAG_W;

  logic hs;

  generate
    if (LAT == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{flush_i, chk_tag_i};
      assign out_valid_o   = in_valid_i;
      assign in_ready_o    = out_ready_i;
      assign out_data_o    = in_data_i;
      assign out_flags_o   = in_flags_i;
      assign out_tag_o     = in_tag_i;
      assign chk_hit_o     = 1'b0;
      assign busy_o        = 1'b0;
    end else begin : g_pipe
      // index 0 is the input port, index k+1 is stage k
      logic [LAT:0]          vld_pipe;
      logic [LAT:0][PW-1:0]  pay_pipe;
      logic [LAT-1:0]        ld;
      logic [LAT-1:0]        hit;

      assign vld_pipe[0] = in_valid_i;
      assign pay_pipe[0] = {in_data_i, in_flags_i, in_tag_i};

      for (genvar k = 0; k < LAT; k++) begin : g_stage
        // a stage can load unless it and everything downstream is full and stalled
        assign ld[k] = out_ready_i || !(&vld_pipe[LAT:k+1]);

        fpu_lat_stage #(.W(PW)) u_stage (
          .clk    (clk_i),
          .rst_n  (rst_ni),
          .flush  (flush_i),
          .ld     (ld[k]),
          .vld_in (vld_pipe[k]),
          .pay_in (pay_pipe[k]),
          .vld    (vld_pipe[k+1]),
          .pay    (pay_pipe[k+1])
        );

        assign hit[k] = vld_pipe[k+1] && (pay_pipe[k+1][TAG_W-1:0] == chk_tag_i);
      end

      assign in_ready_o  = ld[0];
      assign out_valid_o = vld_pipe[LAT];
      assign {out_data_o, out_flags_o, out_tag_o} = pay_pipe[LAT];
      assign chk_hit_o   = |hit;
      assign busy_o      = |vld_pipe[LAT:1];
    end
  endgenerate

  assign hs = out_valid_o && out_ready_i;

  // clear takes effect before the same-cycle accumulate
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           fflags_o <= '0;
    else if (fflags_clr_i) fflags_o <= hs ? out_flags_o : '0;
    else if (hs)           fflags_o <= fflags_o | out_flags_o;
  end

endmodule

// File: tb/tb_fpu_lat_pipe.sv
// Randomized bench for fpu_lat_pipe: LAT=3 instance against a positional queue model,
// plus a LAT=0 instance sharing the same stimulus.

module tb_fpu_lat_pipe;

  localparam int LAT = 3;
  localparam int DW  = 32;
  localparam int FW  = 5;
  localparam int TW  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, in_valid, out_ready, fflags_clr;
  logic [DW-1:0] in_data;
  logic [FW-1:0] in_flags;
  logic [TW-1:0] in_tag, chk_tag;

  logic          in_ready, out_valid, chk_hit, busy;
  logic [DW-1:0] out_data;
  logic [FW-1:0] out_flags, fflags;
  logic [TW-1:0] out_tag;

  logic          in_ready0, out_valid0, chk_hit0, busy0;
  logic [DW-1:0] out_data0;
  logic [FW-1:0] out_flags0, fflags0;
  logic [TW-1:0] out_tag0;

  fpu_lat_pipe #(.DATA_W(DW), .FLAG_W(FW), .TAG_W(TW), .LAT(LAT)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_flags_i(in_flags), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_flags_o(out_flags), .out_tag_o(out_tag),
    .chk_tag_i(chk_tag), .chk_hit_o(chk_hit), .busy_o(busy),
    .fflags_o(fflags), .fflags_clr_i(fflags_clr)
  );

  fpu_lat_pipe #(.DATA_W(DW), .FLAG_W(FW), .TAG_W(TW), .LAT(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_data_i(in_data), .in_flags_i(in_flags), .in_tag_i(in_tag),
    .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .out_data_o(out_data0), .out_flags_o(out_flags0), .out_tag_o(out_tag0),
    .chk_tag_i(chk_tag), .chk_hit_o(chk_hit0), .busy_o(busy0),
    .fflags_o(fflags0), .fflags_clr_i(fflags_clr)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [FW-1:0] f;
    logic [TW-1:0] t;
    int            pos;
  } ent_t;

  ent_t          q[$];
  logic [FW-1:0] m_ff, m_ff0;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, compare against model, advance model to match the coming edge.
  task automatic step(input bit iv, input logic [DW-1:0] d, input logic [FW-1:0] f,
                      input logic [TW-1:0] t, input bit ordy, input bit fl,
                      input bit clr, input logic [TW-1:0] ct);
    bit ov, hs, hit, rdy, hs0;
    int lim;
    @(negedge clk);
    in_valid = iv; in_data = d; in_flags = f; in_tag = t;
    out_ready = ordy; flush = fl; fflags_clr = clr; chk_tag = ct;
    #1;
    ov  = (q.size() > 0) && (q[0].pos == LAT-1);
    hs  = ov && ordy;
    hit = 1'b0;
    foreach (q[i]) if (q[i].t == ct) hit = 1'b1;
    check("out_valid", 64'(out_valid), 64'(ov));
    if (ov) begin
      check("out_data",  64'(out_data),  64'(q[0].d));
      check("out_flags", 64'(out_flags), 64'(q[0].f));
      check("out_tag",   64'(out_tag),   64'(q[0].t));
    end
    check("busy",    64'(busy),    64'(q.size() > 0));
    check("chk_hit", 64'(chk_hit), 64'(hit));
    check("fflags",  64'(fflags),  64'(m_ff));
    // retire, then every entry moves up one slot unless the slot ahead stays taken
    if (hs) begin
      m_ff = clr ? q[0].f : (m_ff | q[0].f);
      void'(q.pop_front());
    end else if (clr) m_ff = '0;
    lim = LAT;
    foreach (q[i]) begin
      if (q[i].pos + 1 < lim) q[i].pos = q[i].pos + 1;
      lim = q[i].pos;
    end
    rdy = (lim > 0);
    check("in_ready", 64'(in_ready), 64'(rdy));
    if (fl) q.delete();
    else if (iv && rdy) q.push_back('{d: d, f: f, t: t, pos: 0});
    // zero-latency instance is a wire plus the sticky register
    check("l0_valid", 64'(out_valid0), 64'(iv));
    check("l0_ready", 64'(in_ready0),  64'(ordy));
    check("l0_data",  64'(out_data0),  64'(d));
    check("l0_flags", 64'(out_flags0), 64'(f));
    check("l0_tag",   64'(out_tag0),   64'(t));
    check("l0_side",  64'({chk_hit0, busy0}), 64'(0));
    check("l0_ff",    64'(fflags0),    64'(m_ff0));
    hs0 = iv && ordy;
    if (clr) m_ff0 = hs0 ? f : '0;
    else if (hs0) m_ff0 = m_ff0 | f;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ov"},  64'(out_valid), 64'(0));
    check({tag, "_od"},  64'(out_data),  64'(0));
    check({tag, "_of"},  64'(out_flags), 64'(0));
    check({tag, "_ot"},  64'(out_tag),   64'(0));
    check({tag, "_hit"}, 64'(chk_hit),   64'(0));
    check({tag, "_bsy"}, 64'(busy),      64'(0));
    check({tag, "_ir"},  64'(in_ready),  64'(1));
    check({tag, "_ff"},  64'(fflags),    64'(0));
    check({tag, "_ff0"}, 64'(fflags0),   64'(0));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    in_valid = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
    q.delete(); m_ff = '0; m_ff0 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
    in_data = '0; in_flags = '0; in_tag = '0; chk_tag = '0;
    m_ff = '0; m_ff0 = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // in-order stream, flags accumulate to 0x15
    step(1, 32'h3F800000, 5'h01, 5'd1, 1, 0, 0, 5'd6);
    step(1, 32'h40000000, 5'h00, 5'd2, 1, 0, 0, 5'd6);
    step(1, 32'h40400000, 5'h04, 5'd3, 1, 0, 0, 5'd6);
    step(1, 32'h40800000, 5'h10, 5'd4, 1, 0, 0, 5'd6);
    repeat (4) step(0, '0, '0, '0, 1, 0, 0, 5'd6);
    check("ff_stream", 64'(fflags), 64'h15);

    // fill under stall, 4th waits, then retire-and-accept in one cycle
    step(0, '0, '0, '0, 0, 0, 1, 5'd7);
    step(1, 32'h11, 5'h01, 5'd1, 0, 0, 0, 5'd7);
    step(1, 32'h22, 5'h02, 5'd2, 0, 0, 0, 5'd7);
    step(1, 32'h33, 5'h08, 5'd7, 0, 0, 0, 5'd7);
    step(1, 32'h44, 5'h04, 5'd4, 0, 0, 0, 5'd7);
    check("full_ir", 64'(in_ready), 64'(0));
    step(1, 32'h44, 5'h04, 5'd4, 1, 0, 0, 5'd7);
    step(0, '0, '0, '0, 0, 0, 0, 5'd7);
    // clear together with a handshake keeps only the retiring flags
    step(0, '0, '0, '0, 1, 0, 1, 5'd7);
    // flush with a new input while entries are in flight
    step(1, 32'h55, 5'h1F, 5'd9, 0, 1, 0, 5'd4);
    step(0, '0, '0, '0, 1, 0, 0, 5'd4);
    check("flush_busy", 64'(busy), 64'(0));
    step(0, '0, '0, '0, 1, 0, 1, 5'd4);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      step($urandom_range(0, 9) < 7, $urandom, FW'($urandom), TW'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0,
           $urandom_range(0, 19) == 0, TW'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
